// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the program-counter register
//   PC_WIDTH        : default address width in bits
//   PC_RESET_VECTOR : default address loaded while reset is asserted
//   pc_t            : program-counter word type at the default width
package pc_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc.sv
// rtl/pc.sv - program-counter register between the next-PC mux and instruction memory
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, loads RESET_VALUE at once
//   proximo_Pc : next program-counter value (PC+4, branch or jump target)
//   stall      : present only when PC_STALL_EN is defined; 1 holds the current value
//   atual_Pc   : current program-counter value, straight from the register
//   Optional build macro: PC_STALL_EN
module pc
  import pc_pkg::*;
#(
  parameter int                    WIDTH       = PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_VALUE = PC_RESET_VECTOR,
  parameter bit                    FORCE_ALIGN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] proximo_Pc,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  output logic [WIDTH-1:0] atual_Pc
);

  // Size cast truncates or zero-extends the reset address to the register width.
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  // Clearing the two low bits keeps every captured address word aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    FORCE_ALIGN ? {{(WIDTH-2){1'b1}}, 2'b00} : {WIDTH{1'b1}};

  logic [WIDTH-1:0] load_value;

  always_comb begin
    load_value = proximo_Pc & ALIGN_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      atual_Pc <= RESET_W;
`ifdef PC_STALL_EN
    end else if (!stall) begin
      atual_Pc <= load_value;
`else
    end else begin
      atual_Pc <= load_value;
`endif
    end
  end

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - self-checking bench for the program-counter register
module tb_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] proximo_Pc;
  logic [31:0] atual_Pc;
  logic [31:0] atual_al;
`ifdef PC_STALL_EN
  logic        stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc dut (
    .clk        (clk),
    .rst        (rst),
    .proximo_Pc (proximo_Pc),
`ifdef PC_STALL_EN
    .stall      (stall),
`endif
    .atual_Pc   (atual_Pc)
  );

  pc #(.FORCE_ALIGN(1'b1)) dut_al (
    .clk        (clk),
    .rst        (rst),
    .proximo_Pc (proximo_Pc),
`ifdef PC_STALL_EN
    .stall      (stall),
`endif
    .atual_Pc   (atual_al)
  );

  typedef struct {
    bit          r;
    logic [31:0] din;
    logic [31:0] exp_plain;
    logic [31:0] exp_align;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: a captured address is the input word, with the low two bits
  // cleared when alignment is requested.
  function automatic logic [31:0] ref_pc(input bit align, input logic [31:0] v);
    return align ? (v & 32'hFFFF_FFFC) : v;
  endfunction

  initial begin
    logic [31:0] m_plain, m_align, v;
    bit          r;
`ifdef PC_STALL_EN
    bit          s;
    stall = 1'b0;
`endif

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010};
    vecs[1] = '{1'b0, 32'h8000_0003, 32'h8000_0003, 32'h8000_0000};
    vecs[2] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h7FFF_FFFC};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h1234_5672, 32'h1234_5672, 32'h1234_5670};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};

    // Reset held for two edges, value visible before any edge, X input ignored.
    rst        = 1'b1;
    proximo_Pc = 32'hAAAA_AAAA;
    #1;
    check("reset_no_clock", atual_Pc, 32'h0);
    check("reset_no_clock_al", atual_al, 32'h0);
    @(posedge clk); #1;
    check("reset_edge1", atual_Pc, 32'h0);
    proximo_Pc = 'x;
    @(posedge clk); #1;
    check("reset_edge2_x", atual_Pc, 32'h0);
    check("reset_edge2_x_al", atual_al, 32'h0);

    // First load after a mid-cycle release.
    @(negedge clk);
    rst        = 1'b0;
    proximo_Pc = 32'h0000_0004;
    #1;
    check("release_no_load", atual_Pc, 32'h0);
    @(posedge clk); #1;
    check("first_load", atual_Pc, 32'h4);
    check("first_load_al", atual_al, 32'h4);

    // Sequencing with one-cycle latency.
    @(negedge clk); proximo_Pc = 32'h0000_0008;
    @(posedge clk); #1; check("seq_8", atual_Pc, 32'h8);
    @(negedge clk); proximo_Pc = 32'h0000_000C;
    #1; check("seq_hold_before_edge", atual_Pc, 32'h8);
    @(posedge clk); #1; check("seq_C", atual_Pc, 32'hC);

    // Asynchronous reset between edges while holding 8.
    @(negedge clk); proximo_Pc = 32'h0000_0008;
    @(posedge clk); #1; check("pre_async_8", atual_Pc, 32'h8);
    #1 rst = 1'b1;
    #1;
    check("async_reset", atual_Pc, 32'h0);
    check("async_reset_al", atual_al, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Extremes.
    @(negedge clk); proximo_Pc = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("ones_plain", atual_Pc, 32'hFFFF_FFFF);
    check("ones_align", atual_al, 32'hFFFF_FFFC);

    // Table vectors, one per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst        = vecs[i].r;
      proximo_Pc = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d_plain", i), atual_Pc, vecs[i].exp_plain);
      check($sformatf("vec%0d_align", i), atual_al, vecs[i].exp_align);
    end
    @(negedge clk); rst = 1'b0;

`ifdef PC_STALL_EN
    // Stall holds the value for two edges, then the pending address loads.
    proximo_Pc = 32'h0000_0010;
    @(posedge clk); #1; check("stall_pre", atual_Pc, 32'h10);
    @(negedge clk); stall = 1'b1; proximo_Pc = 32'h0000_0014;
    @(posedge clk); #1; check("stall_edge1", atual_Pc, 32'h10);
    @(posedge clk); #1; check("stall_edge2", atual_Pc, 32'h10);
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1; check("stall_release", atual_Pc, 32'h14);
    // Reset wins over stall.
    @(negedge clk); stall = 1'b1; rst = 1'b1;
    #1; check("rst_over_stall", atual_Pc, 32'h0);
    @(negedge clk); rst = 1'b0; stall = 1'b0;
`endif

    // Randomized run against the reference model.
    proximo_Pc = 32'h0;
    @(posedge clk); #1;
    m_plain = 32'h0;
    m_align = 32'h0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = ($urandom_range(0, 15) == 0);
      v = $urandom;
      rst        = r;
      proximo_Pc = v;
`ifdef PC_STALL_EN
      s = ($urandom_range(0, 3) == 0);
      stall = s;
`endif
      if (r) begin
        #1;
        check("rand_async", atual_Pc, 32'h0);
        m_plain = 32'h0;
        m_align = 32'h0;
`ifdef PC_STALL_EN
      end else if (s) begin
        // hold: model unchanged
`endif
      end else begin
        m_plain = ref_pc(1'b0, v);
        m_align = ref_pc(1'b1, v);
      end
      @(posedge clk); #1;
      check("rand_plain", atual_Pc, m_plain);
      check("rand_align", atual_al, m_align);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
